// File: rtl/seq_pkg.sv
// Shared types and defaults for the bit-stream sequence detector front end.
// Holds the serializer FSM encoding and the default word width.
package seq_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_DATA_W_DEFAULT = 8;

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: a one-word holding buffer feeds a shifter that
// emits one bit per clk on dout, with IDLE_BIT filler whenever no word is in flight.
module word_serializer
    import seq_pkg::*;
#(
    parameter int DATA_W    = SER_DATA_W_DEFAULT,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              dout,
    output logic              dout_active,
    output logic              word_done
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W - 1);

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic              r_buf_full;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_dout;
    logic              r_active;
    logic              r_done;

    logic              w_accept;
    logic              w_load;
    logic              w_shift;
    logic              w_last;
    logic              w_out_bit;
    logic [DATA_W-1:0] w_sh_next;

    // in_ready depends on registered state only, never on in_valid.
    assign in_ready    = !r_buf_full;
    assign w_accept    = in_valid && !r_buf_full;
    assign w_last      = (r_cnt == '0);
    assign w_out_bit   = MSB_FIRST ? r_sh[DATA_W-1] : r_sh[0];
    assign w_sh_next   = MSB_FIRST ? {r_sh[DATA_W-2:0], 1'b0} : {1'b0, r_sh[DATA_W-1:1]};

    assign dout        = r_dout;
    assign dout_active = r_active;
    assign word_done   = r_done;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!resetn) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (r_buf_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                w_shift = 1'b1;
                // On the last bit, reload straight from the buffer to keep the stream gapless.
                if (w_last) begin
                    if (r_buf_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = SER_IDLE;
                    end
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_buf_full <= 1'b0;
            r_dout     <= IDLE_BIT;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Accept requires an empty buffer and load a full one, so they never collide.
            if (w_load) begin
                r_buf_full <= 1'b0;
            end else if (w_accept) begin
                r_buf_full <= 1'b1;
            end

            if (w_shift) begin
                r_dout   <= w_out_bit;
                r_active <= 1'b1;
                r_done   <= w_last;
            end else begin
                r_dout   <= IDLE_BIT;
                r_active <= 1'b0;
                r_done   <= 1'b0;
            end
        end
    end

    // NOTE: payload registers carry no reset; they are only read after a load qualified by reset-cleared flags.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf <= in_data;
        end

        if (w_load) begin
            r_sh  <= r_buf;
            r_cnt <= CNT_LOAD;
        end else if (w_shift) begin
            r_sh  <= w_sh_next;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: stimulus pushes expected bits per accepted
// word, per-instance monitors pop and compare whenever dout_active is high.
module tb_word_serializer;
    import seq_pkg::*;

    typedef struct packed {
        logic b;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;

    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic       m_ready, l_ready;
    logic       m_dout, l_dout;
    logic       m_active, l_active;
    logic       m_done, l_done;

    exp_t       q_m[$];
    exp_t       q_l[$];
    exp_t       e_m, e_l;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_en   = 1'b0;
    int         st;

    always #5 clk = ~clk;

    word_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .resetn(resetn), .in_data(m_data), .in_valid(m_valid),
        .in_ready(m_ready), .dout(m_dout), .dout_active(m_active), .word_done(m_done)
    );

    word_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .resetn(resetn), .in_data(l_data), .in_valid(l_valid),
        .in_ready(l_ready), .dout(l_dout), .dout_active(l_active), .word_done(l_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_word(input bit lsb, input logic [7:0] d);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b    = lsb ? d[i] : d[7-i];
            e.done = (i == 7);
            if (lsb) q_l.push_back(e);
            else     q_m.push_back(e);
        end
    endtask

    // Holds in_valid until accepted; stalls counts edges where in_ready was low.
    task automatic send(input bit lsb, input logic [7:0] d, output int stalls);
        bit rdy;
        bit acc;
        stalls = 0;
        acc    = 1'b0;
        if (lsb) begin l_valid = 1'b1; l_data = d; end
        else     begin m_valid = 1'b1; m_data = d; end
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            rdy = lsb ? l_ready : m_ready;
            @(posedge clk);
            if (rdy) begin
                acc = 1'b1;
                push_word(lsb, d);
            end else begin
                stalls++;
            end
        end
        if (!acc) fail("send_timeout");
        #1;
        if (lsb) l_valid = 1'b0;
        else     m_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit lsb);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk);
            #2;
            if (lsb) done = (q_l.size() == 0) && !l_active;
            else     done = (q_m.size() == 0) && !m_active;
        end
        check(lsb ? "l_drain" : "m_drain", lsb ? q_l.size() : q_m.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_active) begin
                if (q_m.size() == 0) begin
                    fail("m_unexpected_bit");
                end else begin
                    e_m = q_m.pop_front();
                    check("m_dout", m_dout, e_m.b);
                    check("m_word_done", m_done, e_m.done);
                end
            end else begin
                check("m_idle_dout", m_dout, 0);
                check("m_idle_done", m_done, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (l_active) begin
                if (q_l.size() == 0) begin
                    fail("l_unexpected_bit");
                end else begin
                    e_l = q_l.pop_front();
                    check("l_dout", l_dout, e_l.b);
                    check("l_word_done", l_done, e_l.done);
                end
            end else begin
                check("l_idle_dout", l_dout, 0);
                check("l_idle_done", l_done, 0);
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        m_valid = 1'b0; l_valid = 1'b0;
        m_data  = 8'h00; l_data = 8'h00;

        // Reset held three cycles with no traffic.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_dout", m_dout, 0);
        check("rst_m_active", m_active, 0);
        check("rst_m_done", m_done, 0);
        check("rst_m_ready", m_ready, 1);
        check("rst_l_dout", l_dout, 0);
        check("rst_l_active", l_active, 0);
        check("rst_l_ready", l_ready, 1);
        resetn = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single MSB-first word with latency check.
        send(1'b0, 8'hA5, st);
        check("t2_stalls", st, 0);
        @(posedge clk);
        @(negedge clk);
        check("t2_load_cycle_active", m_active, 0);
        @(posedge clk);
        @(negedge clk);
        check("t2_first_bit_active", m_active, 1);
        wait_drain(1'b0);
        check("t2_after_dout", m_dout, 0);
        check("t2_after_active", m_active, 0);

        // Two words back to back must form 16 contiguous bits.
        send(1'b0, 8'h0A, st);
        send(1'b0, 8'hA0, st);
        check("t3_second_stalls", st, 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t3_contiguous", m_active, 1);
            if (i == 0) check("t3_ready_while_full", m_ready, 0);
            @(posedge clk);
        end
        wait_drain(1'b0);

        // Third word held valid while buffer full: stalls until the reload edge.
        send(1'b0, 8'h3C, st);
        send(1'b0, 8'hC3, st);
        send(1'b0, 8'h5A, st);
        check("t6_stalls", st, 7);
        wait_drain(1'b0);

        // Reset after three bits of 8'hFF with 8'h0F buffered.
        send(1'b0, 8'hFF, st);
        send(1'b0, 8'h0F, st);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("t5_bits_seen", q_m.size(), 13);
        q_m.delete();
        @(negedge clk);
        check("t5_dout", m_dout, 0);
        check("t5_active", m_active, 0);
        check("t5_ready", m_ready, 1);
        check("t5_done", m_done, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // LSB-first instance.
        send(1'b1, 8'h01, st);
        wait_drain(1'b1);
        send(1'b1, 8'hB4, st);
        wait_drain(1'b1);

        repeat (3) @(posedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
